// File: rtl/sound_pkg.sv
// sound_pkg: definitions shared by the tone path (note sequencer and
// tone_square_gen).
//   tone_state_e : square-wave generator state (IDLE / HIGH / LOW)
//   TONE_W       : default tone word width
//   TONE_SILENCE : largest tone word that means "no tone"
package sound_pkg;

  localparam int TONE_W       = 16;
  localparam int TONE_SILENCE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } tone_state_e;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: prescaler producing one tick every PRESCALE clock cycles.
//   sound_clock : clock
//   rst_n       : asynchronous active-low reset
//   clear       : restart the count at 0 on the next edge
//   tick        : high on the cycle the count equals PRESCALE-1
//                 (high every cycle when PRESCALE = 1)
module tick_divider #(
  parameter int PRESCALE = 50
) (
  input  logic sound_clock,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge sound_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tone_square_gen.sv
// tone_square_gen: turns a tone word (half-period in prescaled ticks) into a
// click-free square wave. A tone is latched only at the start of a period,
// and a stop or tone change takes effect only at a full-period boundary.
//   sound_clock : clock
//   rst_n       : asynchronous active-low reset
//   sound       : tone word, half-period in ticks; 0 or 1 = silence
//   enable      : play request; 0 stops at the end of the current period
//   speaker     : square-wave output (high during HIGH)
//   active      : high while a period is in progress (HIGH or LOW)
//   period_done : one-cycle pulse at the end of each full period
module tone_square_gen
  import sound_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int TW       = TONE_W
) (
  input  logic          sound_clock,
  input  logic          rst_n,
  input  logic [TW-1:0] sound,
  input  logic          enable,
  output logic          speaker,
  output logic          active,
  output logic          period_done
);

  tone_state_e   state, next_state;
  logic [TW-1:0] hcnt;
  logic [TW-1:0] cur;
  logic          tick;
  logic          tick_clear;
  logic          tone_req;
  logic          half_end;
  logic          enter_high;
  logic          speaker_d, active_d, period_done_d;

  // A tone is only playable if the word is above the silence threshold.
  assign tone_req   = enable && (sound > TW'(TONE_SILENCE));
  // cur >= 2 whenever HIGH/LOW is active, so cur-1 cannot underflow there.
  assign half_end   = tick && (hcnt == cur - TW'(1));
  assign enter_high = (next_state == HIGH) && (state != HIGH);
  // Counter is parked in IDLE and restarted at each period start, so every
  // half-period is exactly cur*PRESCALE cycles.
  assign tick_clear = (state == IDLE) || enter_high;

  tick_divider #(
    .PRESCALE (PRESCALE)
  ) u_tick_divider (
    .sound_clock (sound_clock),
    .rst_n       (rst_n),
    .clear       (tick_clear),
    .tick        (tick)
  );

  // State register.
  always_ff @(posedge sound_clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (tone_req) next_state = HIGH;
      HIGH: if (half_end) next_state = LOW;
      LOW:  if (half_end) next_state = tone_req ? HIGH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode, computed from the next state and registered below so the
  // outputs change on the same edge as the state.
  always_comb begin
    speaker_d     = (next_state == HIGH);
    active_d      = (next_state != IDLE);
    period_done_d = (state == LOW) && half_end;
  end

  always_ff @(posedge sound_clock or negedge rst_n) begin
    if (!rst_n) begin
      speaker     <= 1'b0;
      active      <= 1'b0;
      period_done <= 1'b0;
    end else begin
      speaker     <= speaker_d;
      active      <= active_d;
      period_done <= period_done_d;
    end
  end

  // Half-period counter: restarts on every state change, counts ticks.
  always_ff @(posedge sound_clock or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
    end else if (next_state != state) begin
      hcnt <= '0;
    end else if (tick && (state != IDLE)) begin
      hcnt <= hcnt + TW'(1);
    end
  end

  // Tone register: sound is sampled only at the start of a period.
  always_ff @(posedge sound_clock or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
    end else if (enter_high) begin
      cur <= sound;
    end
  end

endmodule

// File: tb/tb_tone_square_gen.sv
// tb_tone_square_gen: directed bench for tone_square_gen. Two instances share
// one clock: dut4 (PRESCALE=4) and dut1 (PRESCALE=1). Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
module tb_tone_square_gen;

  logic        clk = 1'b0;
  logic        rst4_n, en4, spk4, act4, pd4;
  logic [15:0] snd4;
  logic        rst1_n, en1, spk1, act1, pd1;
  logic [15:0] snd1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tone_square_gen #(.PRESCALE(4), .TW(16)) dut4 (
    .sound_clock (clk),
    .rst_n       (rst4_n),
    .sound       (snd4),
    .enable      (en4),
    .speaker     (spk4),
    .active      (act4),
    .period_done (pd4)
  );

  tone_square_gen #(.PRESCALE(1), .TW(16)) dut1 (
    .sound_clock (clk),
    .rst_n       (rst1_n),
    .sound       (snd1),
    .enable      (en1),
    .speaker     (spk1),
    .active      (act1),
    .period_done (pd1)
  );

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic spk(input int sel);
    return (sel == 4) ? spk4 : spk1;
  endfunction

  // Count consecutive sampled cycles (starting with the current one) on which
  // speaker equals lvl; bounded so a stuck output cannot hang the run.
  task automatic run_len(input int sel, input logic lvl, output int n);
    n = 0;
    while ((spk(sel) === lvl) && (n < 3000)) begin
      n++;
      step();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hi, lo, bad;

    rst4_n = 1'b0; en4 = 1'b0; snd4 = '0;
    rst1_n = 1'b0; en1 = 1'b0; snd1 = '0;
    repeat (2) step();
    check("reset_out_p4", {29'd0, spk4, act4, pd4}, 32'd0);
    check("reset_out_p1", {29'd0, spk1, act1, pd1}, 32'd0);
    rst4_n = 1'b1; rst1_n = 1'b1;
    step();
    check("idle_after_release", {29'd0, spk4, act4, pd4}, 32'd0);

    // Steady tone: PRESCALE=4, sound=3 -> 12 high / 12 low.
    en4 = 1'b1; snd4 = 16'd3;
    step();
    check("start_latency", {29'd0, spk4, act4, pd4}, 32'b110);
    run_len(4, 1'b1, n);
    check("p4_high_len", n, 12);
    check("p4_low_active", {30'd0, act4, pd4}, 32'b10);
    run_len(4, 1'b0, n);
    check("p4_low_len", n, 12);
    check("p4_done_on_rise", {30'd0, pd4, spk4}, 32'b11);
    step();
    check("p4_done_one_cycle", pd4, 0);
    run_len(4, 1'b1, n);
    check("p4_high_len_2", n, 11);
    run_len(4, 1'b0, n);
    check("p4_low_len_2", n, 12);
    check("p4_done_2", pd4, 1);

    // Stop request 5 cycles into HIGH: the period still completes.
    repeat (5) step();
    en4 = 1'b0;
    run_len(4, 1'b1, n);
    check("stop_high_rest", n, 7);
    n = 0;
    while (!pd4 && n < 100) begin
      n++;
      step();
    end
    check("stop_low_len", n, 12);
    check("stop_outputs", {30'd0, act4, spk4}, 32'd0);
    step();
    check("stop_done_clears", pd4, 0);
    bad = 0;
    repeat (10) begin
      step();
      if (act4 || spk4 || pd4) bad++;
    end
    check("stop_stays_idle", bad, 0);

    // Silence words: 1 then 0 never start a period.
    en4 = 1'b1; snd4 = 16'd1;
    bad = 0;
    repeat (12) begin
      step();
      if (act4 || spk4) bad++;
    end
    check("silence_word_1", bad, 0);
    snd4 = 16'd0;
    bad = 0;
    repeat (12) begin
      step();
      if (act4 || spk4) bad++;
    end
    check("silence_word_0", bad, 0);

    // Tone change on the exact cycle that ends LOW: 3 -> 5.
    snd4 = 16'd3;
    step();
    check("restart_high", spk4, 1);
    run_len(4, 1'b1, n);
    check("pre_change_high", n, 12);
    repeat (11) step();
    snd4 = 16'd5;
    check("boundary_still_low", {30'd0, spk4, act4}, 32'b01);
    step();
    check("boundary_done_rise", {30'd0, pd4, spk4}, 32'b11);
    run_len(4, 1'b1, n);
    check("new_tone_high_len", n, 20);

    // Asynchronous reset mid-LOW.
    repeat (3) step();
    check("pre_reset_active", act4, 1);
    #2 rst4_n = 1'b0;
    #1 check("reset_mid_low", {29'd0, spk4, act4, pd4}, 32'd0);
    snd4 = 16'd3;
    #1 rst4_n = 1'b1;
    step();
    check("restart_after_reset", spk4, 1);
    // Asynchronous reset mid-HIGH.
    repeat (4) step();
    #2 rst4_n = 1'b0;
    #1 check("reset_mid_high", {29'd0, spk4, act4, pd4}, 32'd0);
    #1 rst4_n = 1'b1;
    step();
    run_len(4, 1'b1, n);
    check("first_half_after_reset", n, 12);
    en4 = 1'b0;

    // PRESCALE=1, sound=565, then 2 applied mid-HIGH.
    en1 = 1'b1; snd1 = 16'd565;
    step();
    check("p1_start", spk1, 1);
    run_len(1, 1'b1, hi);
    run_len(1, 1'b0, lo);
    check("p1_half_len", hi, 565);
    check("p1_full_period", hi + lo, 1130);
    check("p1_done", pd1, 1);
    repeat (100) step();
    snd1 = 16'd2;
    run_len(1, 1'b1, hi);
    run_len(1, 1'b0, lo);
    check("p1_change_ignored", hi + 100 + lo, 1130);
    check("p1_done_2", pd1, 1);
    run_len(1, 1'b1, hi);
    run_len(1, 1'b0, lo);
    check("p1_short_period", hi + lo, 4);
    en1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_square_gen.md
# tone_square_gen

Converts the 16-bit tone word produced by the note sequencer into a glitch-free square wave for the parking-sensor speaker. The tone word is a half-period length in prescaled ticks; the values 0 and 1 mean silence. The block sits between the sequencer's `sound` output and the speaker pin. It changes tone only on full-period boundaries, so note changes and stops never produce clicks or runt pulses.

## Interface

- `PRESCALE`, default 50: `sound_clock` cycles per tick; legal range ≥1.
- `TW`, default 16: tone word width.

- `sound_clock`  in  1  sole clock; all state on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `sound`  in  TW  tone word from the sequencer: half-period in ticks; 0 or 1 = silence.
- `enable`  in  1  play request; 0 = stop at the next period end.
- `speaker`  out  1  square-wave output.
- `active`  out  1  high while a tone period is in progress.
- `period_done`  out  1  one-cycle pulse at the end of each full period.

## Operation

- State machine states: IDLE, HIGH, LOW. Reset → IDLE.
- Tick generator: counter 0..PRESCALE-1.
  - Held at 0 in IDLE.
  - Cleared on every entry to HIGH.
  - `tick` asserts on the cycle the counter equals PRESCALE-1.
  - With PRESCALE=1, `tick` is asserted every cycle.
- Half-period counter `hcnt` (TW bits):
  - Advances only on `tick`.
  - Cleared on every state change.
- Tone register `cur`: loaded only on entry to HIGH. `sound` is never sampled mid-period.
- Transitions:
  - IDLE: if `enable`=1 and `sound`>1 → HIGH, with `cur`←`sound`. Otherwise stay in IDLE.
  - HIGH: on `tick` with `hcnt`==`cur`-1 → LOW.
  - LOW: on `tick` with `hcnt`==`cur`-1:
    - pulse `period_done`;
    - if `enable`=1 and `sound`>1 → HIGH, with `cur`←`sound` (a new tone takes effect here);
    - otherwise → IDLE.
- Outputs (all registered):
  - `speaker` = 1 in HIGH, 0 in IDLE and LOW.
  - `active` = 1 in HIGH and LOW.
  - `period_done` is 0 except for the single pulse above.
- Arithmetic: comparisons are unsigned at TW bits. `cur` is always ≥2, so `cur`-1 never underflows. The counter never wraps because it clears at the compare.

## Timing

- Reset values: `speaker`=0, `active`=0, `period_done`=0, state=IDLE, all counters and `cur` = 0.
- Start latency: `enable` and `sound`>1 sampled at edge N → `speaker`=1 and `active`=1 after edge N (visible in cycle N+1).
- Each half-period lasts exactly `cur`×PRESCALE cycles. A full period is 2×`cur`×PRESCALE cycles.
- `period_done` is high for exactly one cycle. It coincides with the cycle in which `speaker` goes from 0 to 1 (next period) or `active` falls (stop).
- Back-to-back periods have no gap cycle between them.
- `enable` deasserted or `sound` dropped to ≤1 mid-period: the current period completes unchanged, then the block goes to IDLE.
- `sound` changed mid-period: ignored until the LOW→HIGH boundary.
- Simultaneous period end and `sound` change on that same cycle: the new value is used. Sampling is at the boundary edge.
- `rst_n` asserted mid-period: `speaker` goes to 0 immediately (asynchronously), with no pulse completion. After release, the block restarts from IDLE.

## Structure

- Shared package `sound_pkg`:
  - state enum (IDLE/HIGH/LOW);
  - `TONE_SILENCE` = 1;
  - `TONE_W` = 16.
  - The sequencer uses the same silence constant.
- One sub-module, `tick_divider`:
  - parameter PRESCALE;
  - inputs: `clear` and `rst_n`;
  - output: a `tick` pulse.
- Everything else lives in the top module.

## Test plan

- PRESCALE=4, `enable`=1, `sound`=3 held → `speaker` alternates 12 cycles high and 12 cycles low. `period_done` pulses every 24 cycles. First high cycle is the cycle after sampling.
- PRESCALE=1, `sound`=565 → full period measures 1130 cycles. Then `sound`=2 applied mid-HIGH → current period stays 1130 cycles, the next period is 4 cycles.
- PRESCALE=4, `sound`=3, `enable` dropped 5 cycles into HIGH → period finishes (24 cycles total), `period_done` pulses once, `active`→0, `speaker` stays 0.
- `sound`=1 and then `sound`=0 with `enable`=1 from IDLE → `active` stays 0 and `speaker` stays 0 indefinitely.
- `rst_n` pulsed low mid-LOW and mid-HIGH → all outputs 0 without waiting for a clock. After release with `sound`=3, the first half-period is a full 12 cycles.
- `sound` switched from 3 to 5 on the exact cycle that ends LOW → the next half-period is 20 cycles (PRESCALE=4), not 12.
